// File: rtl/cordic_bf16_sequencer.sv
// Iterative bfloat16 CORDIC sequencer sharing one external adder across the x/y/z updates.
// Optional vectoring mode (vec_mode port) is built when CORDIC_VECTOR_MODE_EN is defined.
module cordic_bf16_sequencer #(
    parameter int ITER    = 8,
    parameter int ADD_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] z_in,
`ifdef CORDIC_VECTOR_MODE_EN
    input  logic        vec_mode,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x_out,
    output logic [15:0] y_out,
    output logic [15:0] z_out,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_mode,
    input  logic [15:0] add_res,
    output logic        busy
);

    localparam int CW = $clog2(ADD_LAT + 2);
    localparam int IW = 5;

    typedef enum logic [2:0] {IDLE, OPX, OPY, OPZ, COMMIT, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   iter;
    logic [15:0]     xw, yw, zw, xn, yn, zn;
    logic            d_neg;
    logic            acc_dneg, com_dneg;
    logic            op_last, last_iter, eff_sub;
    logic [15:0]     op_res;

    assign op_last   = (cnt == CW'(ADD_LAT));
    assign last_iter = (iter == IW'(ITER - 1));

    // 2^-sh by exponent decrement; anything that would reach exp<=0 flushes to +0
    function automatic logic [15:0] scale(input logic [15:0] v, input logic [IW-1:0] sh);
        if (v[14:7] <= {3'b000, sh}) return 16'h0000;
        return {v[15], v[14:7] - {3'b000, sh}, v[6:0]};
    endfunction

    function automatic logic [15:0] atan_rom(input logic [IW-1:0] idx);
        case (idx)
            5'd0:  return 16'h3F49;
            5'd1:  return 16'h3EED;
            5'd2:  return 16'h3E7B;
            5'd3:  return 16'h3DFF;
            5'd4:  return 16'h3D80;
            5'd5:  return 16'h3D00;
            5'd6:  return 16'h3C80;
            5'd7:  return 16'h3C00;
            5'd8:  return 16'h3B80;
            5'd9:  return 16'h3B00;
            5'd10: return 16'h3A80;
            5'd11: return 16'h3A00;
            5'd12: return 16'h3980;
            5'd13: return 16'h3900;
            5'd14: return 16'h3880;
            5'd15: return 16'h3800;
            default: return 16'h0000;
        endcase
    endfunction

`ifdef CORDIC_VECTOR_MODE_EN
    logic vm;
    assign acc_dneg = vec_mode ? ~y_in[15] : z_in[15];
    assign com_dneg = vm ? ~yn[15] : zn[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          vm <= 1'b0;
        else if (state == IDLE && in_valid)  vm <= vec_mode;
    end
`else
    assign acc_dneg = z_in[15];
    assign com_dneg = zn[15];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = OPX;
            OPX:     if (op_last)   state_nx = OPY;
            OPY:     if (op_last)   state_nx = OPZ;
            OPZ:     if (op_last)   state_nx = COMMIT;
            COMMIT:  state_nx = last_iter ? DONE : OPX;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        add_a     = 16'h0000;
        add_b     = 16'h0000;
        add_mode  = 1'b0;
        case (state)
            OPX: begin add_a = xw; add_b = scale(yw, iter); add_mode = d_neg;  end
            OPY: begin add_a = yw; add_b = scale(xw, iter); add_mode = ~d_neg; end
            OPZ: begin add_a = zw; add_b = atan_rom(iter);  add_mode = d_neg;  end
            default: ;
        endcase
    end

    // The adder has no zero handling, so zero operands and exact cancellation bypass it
    always_comb begin
        eff_sub = add_mode ? (add_a[15] != add_b[15]) : (add_a[15] == add_b[15]);
        op_res  = add_res;
        if (add_b[14:7] == 8'd0)
            op_res = add_a;
        else if (add_a[14:7] == 8'd0)
            op_res = add_mode ? add_b : {~add_b[15], add_b[14:0]};
        else if (eff_sub && (add_a[14:0] == add_b[14:0]))
            op_res = 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            iter  <= '0;
            d_neg <= 1'b0;
            xw    <= '0;
            yw    <= '0;
            zw    <= '0;
            xn    <= '0;
            yn    <= '0;
            zn    <= '0;
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else begin
            if (state == OPX || state == OPY || state == OPZ)
                cnt <= op_last ? '0 : cnt + 1'b1;
            else
                cnt <= '0;

            case (state)
                IDLE: if (in_valid) begin
                    xw    <= x_in;
                    yw    <= y_in;
                    zw    <= z_in;
                    iter  <= '0;
                    d_neg <= acc_dneg;
                end
                OPX: if (op_last) xn <= op_res;
                OPY: if (op_last) yn <= op_res;
                OPZ: if (op_last) zn <= op_res;
                COMMIT: begin
                    xw    <= xn;
                    yw    <= yn;
                    zw    <= zn;
                    iter  <= iter + 1'b1;
                    d_neg <= com_dneg;
                    if (last_iter) begin
                        x_out <= xn;
                        y_out <= yn;
                        z_out <= zn;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_bf16_sequencer.sv
// Bench for cordic_bf16_sequencer: two instances (ITER=1/ADD_LAT=0, ITER=8/ADD_LAT=2),
// a real-arithmetic adder model, and an iteration-level CORDIC reference model.
module tb_cordic_bf16_sequencer;
    typedef logic [15:0] bf16;

    typedef struct {
        bf16        x, y, z;
        bf16        ex, ey, ez;
        logic [2:0] em;   // {OPZ, OPY, OPX} modes
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid [2];
    logic in_ready [2];
    logic out_valid[2];
    logic out_ready[2];
    logic busy     [2];
    logic add_mode [2];
    bf16  x_in [2], y_in [2], z_in [2];
    bf16  x_out[2], y_out[2], z_out[2];
    bf16  add_a[2], add_b[2], add_res[2];
`ifdef CORDIC_VECTOR_MODE_EN
    logic vec_mode [2];
`endif

    int checks = 0;
    int errors = 0;

    bf16  atan_tab[16];
    bf16  obs_a[16], obs_b[16];
    logic obs_m[16];
    int   run_lat;
    bf16  run_x, run_y, run_z;

    cordic_bf16_sequencer #(.ITER(1), .ADD_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x_in(x_in[0]), .y_in(y_in[0]), .z_in(z_in[0]),
`ifdef CORDIC_VECTOR_MODE_EN
        .vec_mode(vec_mode[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .x_out(x_out[0]), .y_out(y_out[0]), .z_out(z_out[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_mode(add_mode[0]),
        .add_res(add_res[0]), .busy(busy[0]));

    cordic_bf16_sequencer #(.ITER(8), .ADD_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x_in(x_in[1]), .y_in(y_in[1]), .z_in(z_in[1]),
`ifdef CORDIC_VECTOR_MODE_EN
        .vec_mode(vec_mode[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .x_out(x_out[1]), .y_out(y_out[1]), .z_out(z_out[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_mode(add_mode[1]),
        .add_res(add_res[1]), .busy(busy[1]));

    function automatic real b2r(input bf16 h);
        logic [63:0] b;
        if (h[14:7] == 8'd0) return 0.0;
        b = {h[15], 11'(h[14:7]) - 11'd127 + 11'd1023, h[6:0], 45'b0};
        return $bitstoreal(b);
    endfunction

    function automatic bf16 r2b(input real r);
        logic [63:0] b;
        int          e;
        logic [7:0]  m;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return {b[63], 15'h0};
        e = int'(b[62:52]) - 1023 + 127;
        m = {1'b0, b[51:45]};
        if (b[44] && (b[43:0] != 44'd0 || b[45])) m = m + 8'd1;
        if (m[7]) begin m = 8'd0; e = e + 1; end
        if (e <= 0)   return {b[63], 15'h0};
        if (e >= 255) return {b[63], 8'hFF, 7'h0};
        return {b[63], e[7:0], m[6:0]};
    endfunction

    function automatic bf16 fadd(input bf16 a, input bf16 b, input logic mode);
        return r2b(mode ? b2r(a) + b2r(b) : b2r(a) - b2r(b));
    endfunction

    // Combinational adder for u0; 2-stage pipelined adder for u1 (stale results until the last op cycle)
    bf16  pa1, pa2, pb1, pb2;
    logic pm1, pm2;
    always @(posedge clk) begin
        pa1 <= add_a[1]; pb1 <= add_b[1]; pm1 <= add_mode[1];
        pa2 <= pa1;      pb2 <= pb1;      pm2 <= pm1;
    end
    assign add_res[0] = fadd(add_a[0], add_b[0], add_mode[0]);
    assign add_res[1] = fadd(pa2, pb2, pm2);

    function automatic bf16 scl(input bf16 v, input int i);
        int e;
        e = int'(v[14:7]);
        if (e <= i) return 16'h0000;
        return {v[15], 8'(e - i), v[6:0]};
    endfunction

    function automatic bf16 ref_op(input bf16 a, input bf16 b, input logic mode);
        logic es;
        if (b[14:7] == 8'd0) return a;
        if (a[14:7] == 8'd0) return mode ? b : {~b[15], b[14:0]};
        es = mode ? (a[15] != b[15]) : (a[15] == b[15]);
        if (es && a[14:0] == b[14:0]) return 16'h0000;
        return fadd(a, b, mode);
    endfunction

    function automatic void model(input int iters, input bf16 xi, input bf16 yi, input bf16 zi,
                                  input logic vm, output bf16 xo, output bf16 yo, output bf16 zo,
                                  output logic [2:0][15:0] fa, output logic [2:0][15:0] fb,
                                  output logic [2:0] fm);
        bf16  x, y, z, xn, yn, zn;
        logic dn;
        x = xi; y = yi; z = zi;
        fa = '0; fb = '0; fm = '0;
        for (int i = 0; i < iters; i++) begin
            dn = vm ? ~y[15] : z[15];
            xn = ref_op(x, scl(y, i), dn);
            yn = ref_op(y, scl(x, i), ~dn);
            zn = ref_op(z, atan_tab[i], dn);
            if (i == 0) begin
                fa = {z, y, x};
                fb = {atan_tab[0], scl(x, 0), scl(y, 0)};
                fm = {dn, ~dn, dn};
            end
            x = xn; y = yn; z = zn;
        end
        xo = x; yo = y; zo = z;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation on instance k, record first-iteration adder ports, optionally stall in DONE
    task automatic run(input int k, input bf16 x, input bf16 y, input bf16 z, input logic vm,
                       input int hold);
        int t, l;
        l = (k == 0) ? 0 : 2;
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1; x_in[k] = x; y_in[k] = y; z_in[k] = z;
`ifdef CORDIC_VECTOR_MODE_EN
        vec_mode[k] = vm;
`endif
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        t = 0;
        while (!out_valid[k] && t < 400) begin
            if (t < 3 * (l + 1)) begin
                obs_a[t] = add_a[k]; obs_b[t] = add_b[k]; obs_m[t] = add_mode[k];
            end
            @(posedge clk); #1;
            t++;
        end
        run_lat = t;
        run_x = x_out[k]; run_y = y_out[k]; run_z = z_out[k];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid[k] = 1'b1; x_in[k] = bf16'($urandom); y_in[k] = bf16'($urandom);
            z_in[k] = bf16'($urandom);
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid[k]), 32'd1);
            chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
            chk("hold_outputs_stable", {x_out[k], y_out[k]}, {run_x, run_y});
            chk("hold_z_stable", 32'(z_out[k]), 32'(run_z));
        end
        @(negedge clk);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk("idle_after_out_ready", {31'd0, in_ready[k]}, 32'd1);
        chk("not_busy_after_exit", {31'd0, busy[k]}, 32'd0);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic check_vs_model(input int k, input bf16 x, input bf16 y, input bf16 z,
                                  input logic vm, input int hold);
        bf16              ex, ey, ez;
        logic [2:0][15:0] fa, fb;
        logic [2:0]       fm;
        int               l, iters;
        l     = (k == 0) ? 0 : 2;
        iters = (k == 0) ? 1 : 8;
        model(iters, x, y, z, vm, ex, ey, ez, fa, fb, fm);
        run(k, x, y, z, vm, hold);
        chk("latency", 32'(run_lat), 32'(iters * (3 * (l + 1) + 1)));
        chk("x_out", 32'(run_x), 32'(ex));
        chk("y_out", 32'(run_y), 32'(ey));
        chk("z_out", 32'(run_z), 32'(ez));
        for (int j = 0; j < 3; j++)
            for (int c = 0; c <= l; c++)
                chk("op_ports_iter0", {obs_a[j*(l+1)+c], obs_b[j*(l+1)+c][14:0], obs_m[j*(l+1)+c]},
                    {fa[j], fb[j][14:0], fm[j]});
    endtask

    function automatic bf16 rnd_val(input int emin, input int emax);
        if ($urandom_range(0, 7) == 0) return 16'h0000;
        return {1'($urandom_range(0, 1)), 8'($urandom_range(emin, emax)), 7'($urandom)};
    endfunction

    vec_t tbl[5];

    initial begin
        bf16 rx, ry, rz;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            x_in[k] = '0; y_in[k] = '0; z_in[k] = '0;
`ifdef CORDIC_VECTOR_MODE_EN
            vec_mode[k] = 1'b0;
`endif
        end
        for (int i = 0; i < 16; i++) atan_tab[i] = r2b($atan(1.0 / real'(1 << i)));

        tbl[0] = '{16'h3F80, 16'h0000, 16'h3F49, 16'h3F80, 16'h3F80, 16'h0000, 3'b010};
        tbl[1] = '{16'h3F80, 16'h0000, 16'hBF49, 16'h3F80, 16'hBF80, 16'h0000, 3'b101};
        tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBF49, 3'b010};
        tbl[3] = '{16'h4000, 16'h3F80, 16'h0000, 16'h3F80, 16'h4040, 16'hBF49, 3'b010};
        tbl[4] = '{16'h3F80, 16'h3F80, 16'h8000, 16'h4000, 16'h0000, 16'h3F49, 3'b101};

        #12;
        for (int k = 0; k < 2; k++) begin
            chk("reset_in_ready", {31'd0, in_ready[k]}, 32'd1);
            chk("reset_busy", {31'd0, busy[k]}, 32'd0);
            chk("reset_out_valid", {31'd0, out_valid[k]}, 32'd0);
            chk("reset_add_ports", {add_a[k], add_b[k]}, 32'd0);
            chk("reset_outputs", {x_out[k], y_out[k]}, {16'd0, z_out[k] | 16'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 5; n++) begin
            run(0, tbl[n].x, tbl[n].y, tbl[n].z, 1'b0, 0);
            chk("tbl_latency", 32'(run_lat), 32'd4);
            chk("tbl_xy", {run_x, run_y}, {tbl[n].ex, tbl[n].ey});
            chk("tbl_z", 32'(run_z), 32'(tbl[n].ez));
            chk("tbl_modes", {29'd0, obs_m[2], obs_m[1], obs_m[0]}, {29'd0, tbl[n].em});
        end

        for (int n = 0; n < 25; n++) begin
            rx = rnd_val(118, 130); ry = (n % 6 == 5) ? rx : rnd_val(118, 130); rz = rnd_val(116, 127);
            check_vs_model(0, rx, ry, rz, 1'b0, 0);
        end

        check_vs_model(1, 16'h0000, 16'h0380, 16'h3F00, 1'b0, 0);
        check_vs_model(1, 16'h3F80, 16'h0380, 16'hBE80, 1'b0, 0);
        for (int n = 0; n < 15; n++) begin
            rx = rnd_val(118, 130); ry = rnd_val(110, 130); rz = rnd_val(116, 127);
            check_vs_model(1, rx, ry, rz, 1'b0, 0);
        end
        check_vs_model(1, 16'h3F80, 16'h3F00, 16'h3E00, 1'b0, 5);
`ifdef CORDIC_VECTOR_MODE_EN
        check_vs_model(1, 16'h3F80, 16'h3F80, 16'h0000, 1'b1, 0);
        check_vs_model(0, 16'h3F80, 16'hBF80, 16'h0000, 1'b1, 0);
`endif

        // Asynchronous reset in the middle of OPY on the ADD_LAT=2 instance
        @(negedge clk);
        in_valid[1] = 1'b1; x_in[1] = 16'h3F80; y_in[1] = 16'h3F00; z_in[1] = 16'hBE00;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_opy_mode", {31'd0, add_mode[1]}, 32'd0);
        chk("pre_reset_busy", {31'd0, busy[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", {31'd0, in_ready[1]}, 32'd1);
        chk("async_busy", {31'd0, busy[1]}, 32'd0);
        chk("async_out_valid", {31'd0, out_valid[1]}, 32'd0);
        chk("async_add_ab", {add_a[1], add_b[1]}, 32'd0);
        chk("async_add_mode", {31'd0, add_mode[1]}, 32'd0);
        chk("async_xy_out", {x_out[1], y_out[1]}, 32'd0);
        chk("async_z_out", 32'(z_out[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_partial_output", {30'd0, out_valid[1], busy[1]}, 32'd0);
        check_vs_model(1, 16'h3F80, 16'h3F00, 16'hBE00, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
